// File: rtl/i2c_target_bridge.sv
// I2C target with an auto-incrementing byte register file shared with
// the CPU over a zero-wait-state Avalon-MM slave.
module i2c_target_bridge #(
  parameter int         NUM_REGS     = 16,
  parameter logic [6:0] DEFAULT_ADDR = 7'h42
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq,
  input  logic        scl,
  inout  wire         sda
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      scl_q, sda_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            oe_q, oe_d;
  logic            ackd_q, ackd_d;
  logic [AW-1:0]   i2c_ptr_q, i2c_ptr_d;
  logic [7:0]      rx_cnt_q, rx_cnt_d;
  logic            busy_q, busy_d;
  logic            dir_q, dir_d;
  logic            stop_set, nack_set, i2c_we;

  logic [6:0]      own_q;
  logic            enable_q, irq_en_q;
  logic            stop_q, nack_q, irq_q;
  logic [AW-1:0]   mem_ptr_q;
  logic [7:0]      regs_q [NUM_REGS];

  logic            scl_rise, scl_fall;
  logic            start_det, stop_det;
  logic            sda_s;
  logic [7:0]      byte_in, tx_byte;
  logic            mem_acc, cpu_we, st_wr;

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign byte_in   = {shift_q[6:0], sda_s};
  assign tx_byte   = regs_q[i2c_ptr_q];

  // Gating with enable releases the pin the cycle control is written.
  assign sda         = (oe_q & enable_q) ? 1'b0 : 1'bz;
  assign waitrequest = 1'b0;
  assign irq         = irq_q;

  assign mem_acc = (write | read) & (address == 3'd4);
  assign cpu_we  = write & (address == 3'd4);
  assign st_wr   = write & (address == 3'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      oe_q      <= 1'b0;
      ackd_q    <= 1'b0;
      i2c_ptr_q <= '0;
      rx_cnt_q  <= '0;
      busy_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      scl_q     <= {scl_q[1:0], scl};
      sda_q     <= {sda_q[1:0], sda};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      oe_q      <= oe_d;
      ackd_q    <= ackd_d;
      i2c_ptr_q <= i2c_ptr_d;
      rx_cnt_q  <= rx_cnt_d;
      busy_q    <= busy_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    oe_d      = oe_q;
    ackd_d    = ackd_q;
    i2c_ptr_d = i2c_ptr_q;
    rx_cnt_d  = rx_cnt_q;
    busy_d    = busy_q;
    dir_d     = dir_q;
    stop_set  = 1'b0;
    nack_set  = 1'b0;
    i2c_we    = 1'b0;
    if (!enable_q) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      ackd_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      rx_cnt_d  = '0;
      oe_d      = 1'b0;
      ackd_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      oe_d     = 1'b0;
      ackd_d   = 1'b0;
      stop_set = busy_q;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, RX: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_in[7:1] == own_q && byte_in[7:1] != 7'd0) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  dir_d   = byte_in[0];
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                i2c_ptr_d = byte_in[AW-1:0];
                state_d   = PTR_ACK;
              end else begin
                i2c_we    = 1'b1;
                i2c_ptr_d = i2c_ptr_q + AW'(1);
                if (rx_cnt_q != 8'hFF) rx_cnt_d = rx_cnt_q + 8'd1;
                state_d   = RX_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, RX_ACK: begin
          // First fall starts the ACK, second fall ends it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && dir_q) begin
                state_d = TX;
                shift_d = tx_byte;
                oe_d    = ~tx_byte[7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = RX;
              end
            end
          end
        end
        TX: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              oe_d    = 1'b0;
              ackd_d  = 1'b0;
              state_d = TX_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            i2c_ptr_d = i2c_ptr_q + AW'(1);
            if (sda_s) begin
              nack_set = 1'b1;
              state_d  = WAIT_STOP;
            end else begin
              ackd_d = 1'b1;
            end
          end else if (scl_fall && ackd_q) begin
            ackd_d    = 1'b0;
            bit_cnt_d = '0;
            shift_d   = tx_byte;
            oe_d      = ~tx_byte[7];
            state_d   = TX;
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_q     <= DEFAULT_ADDR;
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      stop_q    <= 1'b0;
      nack_q    <= 1'b0;
      irq_q     <= 1'b0;
      mem_ptr_q <= '0;
    end else begin
      irq_q  <= irq_en_q & stop_q;
      stop_q <= (stop_q & ~(st_wr & writedata[2])) | stop_set;
      nack_q <= (nack_q & ~(st_wr & writedata[3])) | nack_set;
      if (write) begin
        case (address)
          3'd0: own_q <= writedata[6:0];
          3'd1: begin
            enable_q <= writedata[0];
            irq_en_q <= writedata[1];
          end
          3'd3: mem_ptr_q <= writedata[AW-1:0];
          default: ;
        endcase
      end
      if (mem_acc) mem_ptr_q <= mem_ptr_q + AW'(1);
    end
  end

  // I2C byte has priority when both sides hit the same entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we && i2c_ptr_q == AW'(i))
          regs_q[i] <= byte_in;
        else if (cpu_we && mem_ptr_q == AW'(i))
          regs_q[i] <= writedata[7:0];
      end
    end
  end

  always_comb begin
    readdata = 32'hDEAD_BEEF;
    case (address)
      3'd0: readdata = 32'(own_q);
      3'd1: readdata = {30'd0, irq_en_q, enable_q};
      3'd2: readdata = {28'd0, nack_q, stop_q, dir_q, busy_q};
      3'd3: readdata = 32'(mem_ptr_q);
      3'd4: readdata = 32'(regs_q[mem_ptr_q]);
      3'd5: readdata = 32'(i2c_ptr_q);
      3'd6: readdata = 32'(rx_cnt_q);
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{writedata[31:8], shift_q[7]};

endmodule

// File: tb/tb_i2c_target_bridge.sv
// Directed bench for i2c_target_bridge: Avalon register vectors plus
// bit-banged I2C master sequences.
module tb_i2c_target_bridge;

  localparam int Q = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        irq;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  wire         sda_w;

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  logic [7:0]  b;
  logic        ack;

  pullup (sda_w);
  assign sda_w = m_sda ? 1'bz : 1'b0;

  always #5 clock = ~clock;

  i2c_target_bridge dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .irq         (irq),
    .scl         (scl),
    .sda         (sda_w)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } av_vec_t;

  av_vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic av_wr(input logic [2:0] a, input logic [31:0] v);
    address = a; writedata = v; write = 1'b1;
    wclk(1);
    write = 1'b0;
  endtask

  task automatic av_rd(input logic [2:0] a, output logic [31:0] v);
    address = a; read = 1'b1;
    #1 v = readdata;
    wclk(1);
    read = 1'b0;
  endtask

  task automatic i_start;
    m_sda = 1'b1; wclk(Q);
    scl = 1'b1;   wclk(Q);
    m_sda = 1'b0; wclk(Q);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic i_stop;
    m_sda = 1'b0; wclk(Q);
    scl = 1'b1;   wclk(Q);
    m_sda = 1'b1; wclk(Q);
  endtask

  task automatic i_wbit(input logic v);
    m_sda = v;  wclk(Q);
    scl = 1'b1; wclk(2 * Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic i_rbit(output logic v);
    m_sda = 1'b1; wclk(Q);
    scl = 1'b1;   wclk(Q);
    v = sda_w;    wclk(Q);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic wb(input logic [7:0] v, input logic exp_ack,
                    input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) i_wbit(v[i]);
    i_rbit(a);
    chk(nm, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic i_rbyte(output logic [7:0] v, input logic nack);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      i_rbit(t);
      v[i] = t;
    end
    i_wbit(nack);
  endtask

  // Last data bit lines a CPU mem_data write up with the target's byte write.
  task automatic wb_collide(input logic [7:0] v, input logic [7:0] cpu,
                            output logic a);
    for (int i = 7; i >= 1; i--) i_wbit(v[i]);
    m_sda = v[0]; wclk(Q);
    scl = 1'b1;   wclk(2);
    address = 3'd4; writedata = {24'd0, cpu}; write = 1'b1;
    wclk(1);
    write = 1'b0;
    wclk(2 * Q - 3);
    scl = 1'b0; wclk(Q);
    i_rbit(a);
  endtask

  initial begin
    vt[0]  = '{1'b0, 3'd0, 32'h0,        32'h42};
    vt[1]  = '{1'b0, 3'd1, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 3'd2, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 3'd7, 32'h0,        32'hDEAD_BEEF};
    vt[4]  = '{1'b0, 3'd3, 32'h0,        32'h0};
    vt[5]  = '{1'b0, 3'd5, 32'h0,        32'h0};
    vt[6]  = '{1'b0, 3'd6, 32'h0,        32'h0};
    vt[7]  = '{1'b1, 3'd0, 32'h1B5,      32'h0};
    vt[8]  = '{1'b0, 3'd0, 32'h0,        32'h35};
    vt[9]  = '{1'b1, 3'd7, 32'h12345678, 32'h0};
    vt[10] = '{1'b0, 3'd7, 32'h0,        32'hDEAD_BEEF};
    vt[11] = '{1'b1, 3'd3, 32'h1D,       32'h0};
    vt[12] = '{1'b0, 3'd3, 32'h0,        32'hD};
    vt[13] = '{1'b0, 3'd4, 32'h0,        32'h0};
    vt[14] = '{1'b0, 3'd3, 32'h0,        32'hE};
    vt[15] = '{1'b1, 3'd0, 32'h42,       32'h0};
    vt[16] = '{1'b1, 3'd1, 32'h3,        32'h0};
    vt[17] = '{1'b0, 3'd1, 32'h0,        32'h3};
    vt[18] = '{1'b0, 3'd0, 32'h0,        32'h42};

    wclk(3);
    reset = 1'b0;
    wclk(2);
    chk("reset sda", {31'd0, sda_w}, 32'd1);
    chk("reset irq", {31'd0, irq}, 32'd0);
    chk("waitrequest", {31'd0, waitrequest}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].wr) begin
        av_wr(vt[i].a, vt[i].wd);
      end else begin
        av_rd(vt[i].a, d);
        chk($sformatf("vec%0d addr%0d", i, vt[i].a), d, vt[i].exp);
      end
    end

    // master write of pointer plus two data bytes
    i_start;
    wb(8'h84, 1'b0, "t2 addr ack");
    wb(8'h03, 1'b0, "t2 ptr ack");
    wb(8'hA5, 1'b0, "t2 d0 ack");
    wb(8'h5A, 1'b0, "t2 d1 ack");
    av_rd(3'd2, d); chk("t2 status open", d, 32'h1);
    i_stop;
    wclk(6);
    av_rd(3'd2, d); chk("t2 status", d, 32'h4);
    av_rd(3'd6, d); chk("t2 rx_count", d, 32'd2);
    av_rd(3'd5, d); chk("t2 i2c_ptr", d, 32'd5);
    chk("t2 irq set", {31'd0, irq}, 32'd1);
    av_wr(3'd3, 32'd3);
    av_rd(3'd4, d); chk("t2 regs3", d, 32'hA5);
    av_rd(3'd4, d); chk("t2 regs4", d, 32'h5A);
    av_wr(3'd2, 32'h4);
    wclk(2);
    chk("t2 irq clear", {31'd0, irq}, 32'd0);
    av_rd(3'd2, d); chk("t2 status clr", d, 32'h0);

    // CPU fills across the wrap, master reads back with repeated START
    av_wr(3'd3, 32'd15);
    av_wr(3'd4, 32'h11);
    av_wr(3'd4, 32'h22);
    av_rd(3'd3, d); chk("t3 mem_ptr wrap", d, 32'd1);
    i_start;
    wb(8'h84, 1'b0, "t3 addr ack");
    wb(8'h0F, 1'b0, "t3 ptr ack");
    i_start;
    wb(8'h85, 1'b0, "t3 raddr ack");
    i_rbyte(b, 1'b0); chk("t3 rd0", {24'd0, b}, 32'h11);
    i_rbyte(b, 1'b1); chk("t3 rd1", {24'd0, b}, 32'h22);
    i_stop;
    wclk(4);
    av_rd(3'd2, d); chk("t3 status", d, 32'hE);
    av_rd(3'd5, d); chk("t3 i2c_ptr", d, 32'd1);
    av_rd(3'd6, d); chk("t3 rx_count", d, 32'd0);
    av_wr(3'd2, 32'hC);

    // foreign address and general call are never acknowledged
    i_start;
    wb(8'h86, 1'b1, "t4 0x86 nack");
    i_stop;
    av_wr(3'd0, 32'h0);
    i_start;
    wb(8'h00, 1'b1, "t4 gcall nack");
    i_stop;
    av_wr(3'd0, 32'h42);
    wclk(4);
    av_rd(3'd2, d); chk("t4 status", d, 32'h2);
    av_wr(3'd3, 32'd3);
    av_rd(3'd4, d); chk("t4 regs3", d, 32'hA5);

    // disable while the target drives a 0 bit
    av_wr(3'd3, 32'd6);
    av_wr(3'd4, 32'h3C);
    i_start;
    wb(8'h84, 1'b0, "t5 addr ack");
    wb(8'h06, 1'b0, "t5 ptr ack");
    i_start;
    wb(8'h85, 1'b0, "t5 raddr ack");
    chk("t5 tx bit low", {31'd0, sda_w}, 32'd0);
    av_wr(3'd1, 32'h2);
    chk("t5 sda release", {31'd0, sda_w}, 32'd1);
    wclk(2);
    av_rd(3'd2, d); chk("t5 status", d, 32'h2);
    i_stop;
    wclk(4);
    av_rd(3'd2, d); chk("t5 no stop", d, 32'h2);
    i_start;
    wb(8'h84, 1'b1, "t5 disabled nack");
    i_stop;
    av_wr(3'd1, 32'h3);

    // same-clock write to regs[2] from both sides
    av_wr(3'd3, 32'd2);
    i_start;
    wb(8'h84, 1'b0, "t6 addr ack");
    wb(8'h02, 1'b0, "t6 ptr ack");
    wb_collide(8'hC3, 8'h77, ack);
    chk("t6 data ack", {31'd0, ack}, 32'd0);
    i_stop;
    wclk(4);
    av_rd(3'd3, d); chk("t6 mem_ptr", d, 32'd3);
    av_wr(3'd3, 32'd2);
    av_rd(3'd4, d); chk("t6 regs2", d, 32'hC3);
    av_rd(3'd6, d); chk("t6 rx_count", d, 32'd1);

    // reset clears the register file and pointers
    reset = 1'b1;
    wclk(2);
    reset = 1'b0;
    wclk(2);
    av_rd(3'd5, d); chk("rst i2c_ptr", d, 32'd0);
    av_wr(3'd3, 32'd2);
    av_rd(3'd4, d); chk("rst regs2", d, 32'd0);
    av_rd(3'd1, d); chk("rst control", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
